// File: rtl/lbm_axis_pkg.sv
// lbm_axis_pkg: lane geometry and packer state encoding shared by the lattice packer
package lbm_axis_pkg;
    localparam int LANE_W    = 16;
    localparam int IN_LANES  = 9;
    localparam int OUT_LANES = 4;
    localparam int BUF_LANES = 12;
    localparam int CNT_W     = $clog2(BUF_LANES + 1);
    typedef enum logic {PACK = 1'b0, DRAIN = 1'b1} state_t;
endpackage

// File: rtl/axis_lattice_packer_if.sv
// axis_lattice_packer_if: AXI-Stream bundle used for both the pixel input and the DMA output
interface axis_lattice_packer_if #(
    parameter int DATA_W = 64,
    parameter int STRB_W = 8
);
    logic [DATA_W-1:0] tdata;
    logic [STRB_W-1:0] tkeep;
    logic [STRB_W-1:0] tstrb;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    modport master (output tdata, tkeep, tstrb, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tstrb, tvalid, tlast, output tready);
endinterface

// File: rtl/lane_fifo_shifter.sv
// lane_fifo_shifter: in-order lane buffer, oldest lane at index 0; lanes at or above count always read zero
module lane_fifo_shifter #(
    parameter int LANE_W    = lbm_axis_pkg::LANE_W,
    parameter int IN_LANES  = lbm_axis_pkg::IN_LANES,
    parameter int OUT_LANES = lbm_axis_pkg::OUT_LANES,
    parameter int BUF_LANES = lbm_axis_pkg::BUF_LANES,
    parameter int CNT_W     = lbm_axis_pkg::CNT_W
) (
    input  logic                        m00_axis_aclk,
    input  logic                        m00_axis_aresetn,
    input  logic                        push,
    input  logic                        pop,
    input  logic [IN_LANES*LANE_W-1:0]  push_data,
    output logic [OUT_LANES*LANE_W-1:0] head,
    output logic [CNT_W-1:0]            count
);
    localparam int BW = BUF_LANES * LANE_W;
    localparam logic [CNT_W-1:0] OUT_C = CNT_W'(OUT_LANES);
    localparam logic [CNT_W-1:0] IN_C  = CNT_W'(IN_LANES);

    logic [BW-1:0]    lanes, lanes_nxt, ext;
    logic [CNT_W-1:0] base, count_nxt;

    assign ext  = BW'(push_data);
    assign head = lanes[OUT_LANES*LANE_W-1:0];

    // the zero tail lets a push simply OR the new beat in above the surviving lanes
    always_comb begin
        base      = pop ? (count > OUT_C ? count - OUT_C : '0) : count;
        count_nxt = push ? base + IN_C : base;
        lanes_nxt = (pop ? lanes >> (OUT_LANES * LANE_W) : lanes) | (push ? ext << (int'(base) * LANE_W) : '0);
    end

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn)
        if (!m00_axis_aresetn) begin
            lanes <= '0;
            count <= '0;
        end else begin
            lanes <= lanes_nxt;
            count <= count_nxt;
        end
endmodule

// File: rtl/axis_lattice_packer.sv
// axis_lattice_packer: repacks 9-lane pixel beats into 4-lane DMA words and flushes a zero-padded tail word at frame end
module axis_lattice_packer #(
    parameter int LANE_W    = lbm_axis_pkg::LANE_W,
    parameter int IN_LANES  = lbm_axis_pkg::IN_LANES,
    parameter int OUT_LANES = lbm_axis_pkg::OUT_LANES,
    parameter int BUF_LANES = lbm_axis_pkg::BUF_LANES
) (
    input  logic                  m00_axis_aclk,
    input  logic                  m00_axis_aresetn,
    axis_lattice_packer_if.slave  s00_axis,
    axis_lattice_packer_if.master m00_axis,
    output logic                  frame_done
);
    import lbm_axis_pkg::*;

    localparam int CW  = $clog2(BUF_LANES + 1);
    localparam int BPL = LANE_W / 8;
    localparam logic [CW-1:0] OUT_C  = CW'(OUT_LANES);
    localparam logic [CW-1:0] ROOM_C = CW'(BUF_LANES - IN_LANES);

    state_t        state, state_nxt;
    logic [CW-1:0] count, kept;
    logic          live, push, pop, tail, unused;

    lane_fifo_shifter #(
        .LANE_W(LANE_W), .IN_LANES(IN_LANES), .OUT_LANES(OUT_LANES), .BUF_LANES(BUF_LANES), .CNT_W(CW)
    ) u_buf (
        .m00_axis_aclk    (m00_axis_aclk),
        .m00_axis_aresetn (m00_axis_aresetn),
        .push             (push),
        .pop              (pop),
        .push_data        (s00_axis.tdata),
        .head             (m00_axis.tdata),
        .count            (count)
    );

    assign unused = ^{s00_axis.tstrb, s00_axis.tkeep};
    assign push   = s00_axis.tvalid & s00_axis.tready;
    assign pop    = m00_axis.tvalid & m00_axis.tready;
    assign tail   = state == DRAIN && count <= OUT_C;
    // in PACK a pop implies at least one full word is buffered, so this never wraps where it matters
    assign kept   = pop ? count - OUT_C : count;

    assign m00_axis.tvalid = count >= OUT_C || (state == DRAIN && count != '0);
    assign m00_axis.tlast  = m00_axis.tvalid && tail;
    assign m00_axis.tstrb  = m00_axis.tkeep;
    assign s00_axis.tready = live && state == PACK && kept <= ROOM_C;

    always_comb begin
        m00_axis.tkeep = '0;
        for (int j = 0; j < OUT_LANES; j++)
            m00_axis.tkeep[j*BPL +: BPL] = {BPL{m00_axis.tvalid && (!tail || j < int'(count))}};
    end

    always_comb begin
        state_nxt = state;
        state_nxt = state == PACK && push && s00_axis.tlast ? DRAIN :
                    state == DRAIN && pop && tail ? PACK : state;
    end

    // live holds off s00_axis_tready until the first edge after reset release
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn)
        if (!m00_axis_aresetn) begin
            state      <= PACK;
            live       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            live       <= 1'b1;
            frame_done <= pop && tail;
        end
endmodule

// File: doc/axis_lattice_packer.md
AXIS_LATTICE_PACKER -- requirements
Module: axis_lattice_packer

Interface
REQ-001 SHALL have parameter LANE_W, default 16, meaning the width of one lattice direction value in bits.
REQ-002 SHALL have parameter IN_LANES, default 9, meaning the number of lanes per input beat (one pixel, 9 directions).
REQ-003 SHALL have parameter OUT_LANES, default 4, meaning the number of lanes per output beat.
REQ-004 SHALL have parameter BUF_LANES, default 12, meaning the internal lane buffer capacity.
REQ-005 m00_axis_aclk  input  1  clock; reset m00_axis_aresetn, asynchronous, active-low; clock m00_axis_aclk.
REQ-006 m00_axis_aresetn  input  1  asynchronous active-low reset.
REQ-007 s00_axis_tdata  input  144  pixel beat from the BRAM read-out controller; lane k = bits [16k+15:16k].
REQ-008 s00_axis_tvalid  input  1, s00_axis_tlast input 1 (last pixel of frame), s00_axis_tstrb input 18 (ignored).
REQ-009 s00_axis_tready  output  1  upstream accept.
REQ-010 m00_axis_tdata  output  64  packed lanes toward DMA; lane 0 of word in bits [15:0].
REQ-011 m00_axis_tvalid  output  1; m00_axis_tready  input  1; m00_axis_tlast  output  1.
REQ-012 m00_axis_tkeep  output  8  byte-valid mask.
REQ-013 frame_done  output  1  one-cycle pulse when the tlast output word is accepted.

Function
REQ-014 Transfer occurs only when valid and ready are both high in the same cycle, on either port.
REQ-015 Lanes SHALL leave in arrival order: input lane 0 first; output word lane j = buffer lane j.
REQ-016 Buffer holds count lanes, 0..BUF_LANES; pop = m00 transfer (removes 4 lanes), push = s00 transfer (adds 9 lanes), both in one cycle allowed; count_next = count - 4*pop + 9*push.
REQ-017 s00_axis_tready = (state == PACK) and (count - 4*pop <= 3); combinational from m00_axis_tready is permitted.
REQ-018 m00_axis_tvalid = (count >= 4) or (state == DRAIN and count > 0); tdata/tkeep/tlast driven directly from registered buffer head, no extra pipeline.
REQ-019 Latency: first output word valid the cycle after the input beat is accepted.
REQ-020 States: PACK, DRAIN. PACK -> DRAIN on accepted s00 beat with tlast; DRAIN -> PACK when the word with m00_axis_tlast is accepted.
REQ-021 In DRAIN, s00_axis_tready SHALL be 0; the final word SHALL carry remaining lanes (1..4), missing lanes zero, tkeep = 2 bits per valid lane from LSB (0x03, 0x0F, 0x3F, 0xFF).
REQ-022 m00_axis_tlast SHALL be high only on the word containing the last lane of a tlast input beat; all other words tkeep = 0xFF.
REQ-023 If DRAIN begins with count = 0 after pop (exact multiple), tlast SHALL have been set on that popped word; DRAIN lasts zero extra words.
REQ-024 Output SHALL hold tdata/tkeep/tlast stable while tvalid high and tready low.
REQ-025 frame_done pulses the cycle after the tlast word transfer.

Reset
REQ-026 On reset assertion: count 0, state PACK, m00_axis_tvalid 0, tlast 0, tkeep 0, tdata 0, frame_done 0, s00_axis_tready 0; reset mid-frame discards buffered lanes.
REQ-027 s00_axis_tready SHALL rise no earlier than the first clock edge after reset deassertion.

Structure
REQ-028 Package lbm_axis_pkg SHALL hold LANE_W, IN_LANES, OUT_LANES, lane-count width and the PACK/DRAIN state encoding.
REQ-029 One sub-module, lane_fifo_shifter (BUF_LANES x LANE_W shift buffer with push/pop/count), is natural; FSM and tkeep/tlast logic stay in the top.

Verification
REQ-030 4 beats, tlast on 4th, m_tready=1 -> 9 words, all tkeep 0xFF, tlast on word 9 only, frame_done one pulse.
REQ-031 1 beat with tlast, lanes 0x0000..0x0008 -> 3 words; word 3 tdata 0x0000_0000_0000_0008, tkeep 0x03, tlast 1.
REQ-032 2 beats, tlast on 2nd -> 5 words, word 5 tkeep 0x0F, lanes 16,17 then zeros.
REQ-033 m_tready held 0 after first beat -> count 9, s_tready 0, output word stable; release -> data order intact.
REQ-034 2500-beat frame, random tvalid/tready -> 5625 words, tlast only on word 5625, lane sequence matches scoreboard.
REQ-035 Reset asserted during DRAIN -> all outputs 0 next edge; fresh 1-beat frame afterwards gives REQ-031 result.
